// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending controller.
// Holds the FSM state type and the coin-index to value mapping.
package vend_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StVend,
    StChange
  } state_t;

  localparam logic [1:0] COIN_IDX0 = 2'd0;
  localparam logic [1:0] COIN_IDX1 = 2'd1;
  localparam logic [1:0] COIN_IDX2 = 2'd2;
  localparam logic [1:0] COIN_IDX3 = 2'd3;

  function automatic int unsigned coin_value(input logic [1:0]  sel,
                                             input int unsigned v0,
                                             input int unsigned v1,
                                             input int unsigned v2,
                                             input int unsigned v3);
    int unsigned val;
    case (sel)
      COIN_IDX0: val = v0;
      COIN_IDX1: val = v1;
      COIN_IDX2: val = v2;
      default:   val = v3;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder: maps coin_sel to its value and adds it to the
// current credit one bit wider than the credit so overflow is visible.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 6,
  parameter int unsigned VAL0     = 1,
  parameter int unsigned VAL1     = 2,
  parameter int unsigned VAL2     = 5,
  parameter int unsigned VAL3     = 10
) (
  input  logic [1:0]          coin_sel,
  input  logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] credit_sum,
  output logic                overflow
);

  if (VAL0 >= (1 << CREDIT_W) || VAL1 >= (1 << CREDIT_W) ||
      VAL2 >= (1 << CREDIT_W) || VAL3 >= (1 << CREDIT_W)) begin : g_val_check
    $error("vend_coin_decode: coin values must fit in CREDIT_W bits");
  end

  logic [CREDIT_W:0] val_w;
  logic [CREDIT_W:0] sum_w;

  always_comb begin
    val_w = (CREDIT_W + 1)'(coin_value(coin_sel, VAL0, VAL1, VAL2, VAL3));
    sum_w = {1'b0, credit} + val_w;
  end

  assign credit_sum = sum_w[CREDIT_W-1:0];
  assign overflow   = sum_w[CREDIT_W];

endmodule

// File: rtl/vend_fsm_param.sv
// Vending controller: coin collection, one-cycle vend pulse, change handshake,
// stock tracking with saturating restock, and cancel/refund.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W   = 6,
  parameter int unsigned STOCK_W    = 4,
  parameter int unsigned VAL0       = 1,
  parameter int unsigned VAL1       = 2,
  parameter int unsigned VAL2       = 5,
  parameter int unsigned VAL3       = 10,
  parameter int unsigned PRICE      = 4,
  parameter int unsigned INIT_STOCK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_sel,
  input  logic                cancel,
  input  logic                restock,
  input  logic [STOCK_W-1:0]  restock_qty,
  input  logic                change_ready,
  output logic                vend,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                sold_out,
  output logic                busy
);

  if (PRICE < 1 || PRICE >= (1 << CREDIT_W)) begin : g_price_check
    $error("vend_fsm_param: PRICE must be in 1..2^CREDIT_W-1");
  end
  if (INIT_STOCK >= (1 << STOCK_W)) begin : g_stock_check
    $error("vend_fsm_param: INIT_STOCK must fit in STOCK_W bits");
  end

  localparam logic [CREDIT_W-1:0] PRICE_C      = CREDIT_W'(PRICE);
  localparam logic [STOCK_W-1:0]  INIT_STOCK_C = STOCK_W'(INIT_STOCK);

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [STOCK_W-1:0]  stock_q;
  logic                sold_out_q;
  logic                vend_q;
  logic                coin_reject_q;
  logic                change_valid_q;
  logic [CREDIT_W-1:0] change_amt_q;
  logic                busy_q;

  logic [CREDIT_W-1:0] credit_sum;
  logic                overflow;
  logic                accepting;
  logic                coin_ok;
  logic [CREDIT_W-1:0] remainder;
  logic [STOCK_W:0]    stock_sum;
  logic [STOCK_W-1:0]  stock_next;

  vend_coin_decode #(
    .CREDIT_W (CREDIT_W),
    .VAL0     (VAL0),
    .VAL1     (VAL1),
    .VAL2     (VAL2),
    .VAL3     (VAL3)
  ) u_coin_decode (
    .coin_sel   (coin_sel),
    .credit     (credit_q),
    .credit_sum (credit_sum),
    .overflow   (overflow)
  );

  assign accepting = (state_q == StIdle) || (state_q == StCollect);
  assign coin_ok   = coin_valid && accepting && (stock_q != '0) && !overflow && !cancel;
  assign remainder = credit_q - PRICE_C;

  // Restock and the vend decrement land on the same edge; saturate the net result.
  always_comb begin
    stock_sum = {1'b0, stock_q};
    if (restock) begin
      stock_sum = stock_sum + {1'b0, restock_qty};
    end
    if (state_q == StVend) begin
      stock_sum = stock_sum - (STOCK_W + 1)'(1);
    end
    stock_next = stock_sum[STOCK_W] ? '1 : stock_sum[STOCK_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      credit_q       <= '0;
      stock_q        <= INIT_STOCK_C;
      sold_out_q     <= (INIT_STOCK_C == '0);
      vend_q         <= 1'b0;
      coin_reject_q  <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      busy_q         <= 1'b0;
    end else begin
      vend_q        <= 1'b0;
      coin_reject_q <= coin_valid && !coin_ok;
      stock_q       <= stock_next;
      sold_out_q    <= (stock_next == '0);

      unique case (state_q)
        StIdle, StCollect: begin
          if (cancel && (state_q == StCollect)) begin
            state_q        <= StChange;
            change_valid_q <= 1'b1;
            change_amt_q   <= credit_q;
            busy_q         <= 1'b1;
          end else if (coin_ok) begin
            credit_q <= credit_sum;
            if (credit_sum >= PRICE_C) begin
              state_q <= StVend;
              vend_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StCollect;
            end
          end
        end

        StVend: begin
          credit_q <= remainder;
          if (remainder != '0) begin
            state_q        <= StChange;
            change_valid_q <= 1'b1;
            change_amt_q   <= remainder;
            busy_q         <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end

        StChange: begin
          if (change_ready) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            busy_q         <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign vend         = vend_q;
  assign coin_reject  = coin_reject_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign credit       = credit_q;
  assign stock        = stock_q;
  assign sold_out     = sold_out_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: transaction-level model checked every cycle plus
// directed vectors with hand-computed expectations.
module tb_vend_fsm_param;

  localparam int CREDIT_W   = 6;
  localparam int STOCK_W    = 4;
  localparam int PRICE      = 4;
  localparam int INIT_STOCK = 4;
  localparam int CREDIT_MAX = (1 << CREDIT_W) - 1;
  localparam int STOCK_MAX  = (1 << STOCK_W) - 1;

  logic                clk;
  logic                rst;
  logic                coin_valid;
  logic [1:0]          coin_sel;
  logic                cancel;
  logic                restock;
  logic [STOCK_W-1:0]  restock_qty;
  logic                change_ready;
  logic                vend;
  logic                coin_reject;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic [CREDIT_W-1:0] credit;
  logic [STOCK_W-1:0]  stock;
  logic                sold_out;
  logic                busy;

  vend_fsm_param #(
    .CREDIT_W   (CREDIT_W),
    .STOCK_W    (STOCK_W),
    .VAL0       (1),
    .VAL1       (2),
    .VAL2       (5),
    .VAL3       (10),
    .PRICE      (PRICE),
    .INIT_STOCK (INIT_STOCK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_sel     (coin_sel),
    .cancel       (cancel),
    .restock      (restock),
    .restock_qty  (restock_qty),
    .change_ready (change_ready),
    .vend         (vend),
    .coin_reject  (coin_reject),
    .change_valid (change_valid),
    .change_amt   (change_amt),
    .credit       (credit),
    .stock        (stock),
    .sold_out     (sold_out),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int mval(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 5;
      default: return 10;
    endcase
  endfunction

  // Model: credit held, change owed (if any), pending vend pulse, stock count.
  // "Collecting" is simply credit>0 while nothing is being dispensed or repaid.
  int m_credit = 0;
  int m_stock  = INIT_STOCK;
  int m_owed   = 0;
  int nstock;
  bit m_vend   = 0;
  bit m_rej    = 0;
  bit m_valid  = 0;
  bit model_ok = 0;
  bit busy_now;
  bit got_vend;

  always @(posedge clk) begin
    if (rst) begin
      m_credit = 0;
      m_stock  = INIT_STOCK;
      m_owed   = 0;
      m_vend   = 0;
      m_rej    = 0;
      m_valid  = 0;
      model_ok = 1;
    end else begin
      busy_now = m_vend || m_valid;
      m_rej    = coin_valid && (busy_now || m_stock == 0 || cancel ||
                                (m_credit + mval(coin_sel) > CREDIT_MAX));
      nstock   = m_stock;
      got_vend = 0;
      if (m_vend) begin
        m_credit = m_credit - PRICE;
        nstock   = nstock - 1;
        if (m_credit > 0) begin
          m_valid = 1;
          m_owed  = m_credit;
        end
      end else if (m_valid) begin
        if (change_ready) begin
          m_valid  = 0;
          m_credit = 0;
        end
      end else if (cancel) begin
        if (m_credit > 0) begin
          m_valid = 1;
          m_owed  = m_credit;
        end
      end else if (coin_valid && !m_rej) begin
        m_credit = m_credit + mval(coin_sel);
        got_vend = (m_credit >= PRICE);
      end
      if (restock) nstock = nstock + int'(restock_qty);
      m_stock = (nstock > STOCK_MAX) ? STOCK_MAX : nstock;
      m_vend  = got_vend;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_vend", vend, m_vend);
      chk("m_coin_reject", coin_reject, m_rej);
      chk("m_change_valid", change_valid, m_valid);
      if (m_valid) chk("m_change_amt", change_amt, m_owed);
      chk("m_credit", credit, m_credit);
      chk("m_stock", stock, m_stock);
      chk("m_sold_out", sold_out, m_stock == 0);
      chk("m_busy", busy, m_vend || m_valid);
    end
  end

  task automatic tick(input bit r, input bit cv, input logic [1:0] sel, input bit cn,
                      input bit rs, input logic [STOCK_W-1:0] q, input bit cr);
    rst          = r;
    coin_valid   = cv;
    coin_sel     = sel;
    cancel       = cn;
    restock      = rs;
    restock_qty  = q;
    change_ready = cr;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    tick(0, 0, 2'd0, 0, 0, '0, 0);
  endtask
  task automatic coin(input logic [1:0] sel);
    tick(0, 1, sel, 0, 0, '0, 0);
  endtask
  task automatic do_reset();
    tick(1, 0, 2'd0, 0, 0, '0, 0);
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("rst_credit", credit, 0);
    chk("rst_stock", stock, INIT_STOCK);
    chk("rst_vend", vend, 0);
    chk("rst_change_valid", change_valid, 0);
    chk("rst_change_amt", change_amt, 0);
    chk("rst_busy", busy, 0);

    // Two 2-unit coins reach the price exactly.
    coin(2'd1);
    chk("s1_credit2", credit, 2);
    chk("s1_vend_early", vend, 0);
    coin(2'd1);
    chk("s1_credit4", credit, 4);
    chk("s1_vend", vend, 1);
    idle();
    chk("s1_vend_off", vend, 0);
    chk("s1_no_change", change_valid, 0);
    chk("s1_stock3", stock, 3);
    chk("s1_credit0", credit, 0);

    // 5-unit coin: vend then 1 unit of change.
    coin(2'd2);
    chk("s2_vend", vend, 1);
    idle();
    chk("s2_cv", change_valid, 1);
    chk("s2_amt", change_amt, 1);
    chk("s2_stock2", stock, 2);
    tick(0, 0, 2'd0, 0, 0, '0, 1);
    chk("s2_cv_off", change_valid, 0);
    chk("s2_credit0", credit, 0);
    chk("s2_busy0", busy, 0);

    // Cancel refunds full credit without vending.
    do_reset();
    coin(2'd0);
    chk("s3_credit1", credit, 1);
    tick(0, 0, 2'd0, 1, 0, '0, 0);
    chk("s3_cv", change_valid, 1);
    chk("s3_amt", change_amt, 1);
    chk("s3_vend", vend, 0);
    chk("s3_stock4", stock, 4);
    tick(0, 0, 2'd0, 0, 0, '0, 1);
    chk("s3_credit0", credit, 0);
    tick(0, 1, 2'd3, 1, 0, '0, 0);
    chk("s3_cancel_coin_rej", coin_reject, 1);
    chk("s3_cancel_idle_cv", change_valid, 0);
    chk("s3_cancel_credit", credit, 0);

    // Sell out, reject, restock, accept.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      coin(2'd1);
      coin(2'd1);
      idle();
    end
    chk("s4_stock0", stock, 0);
    chk("s4_sold_out", sold_out, 1);
    coin(2'd3);
    chk("s4_reject", coin_reject, 1);
    chk("s4_credit0", credit, 0);
    tick(0, 0, 2'd0, 0, 1, 4'd2, 0);
    chk("s4_restock", stock, 2);
    chk("s4_not_sold_out", sold_out, 0);
    coin(2'd1);
    chk("s4_accept", coin_reject, 0);
    chk("s4_credit2", credit, 2);

    // Change held while hopper stalls and coins bounce.
    coin(2'd2);
    chk("s5_vend", vend, 1);
    idle();
    chk("s5_amt3", change_amt, 3);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 2'd1, 0, 0, '0, 0);
      chk("s5_stall_rej", coin_reject, 1);
      chk("s5_stall_amt", change_amt, 3);
      chk("s5_stall_busy", busy, 1);
      chk("s5_stall_credit", credit, 3);
    end
    tick(0, 0, 2'd0, 0, 0, '0, 1);
    chk("s5_done_cv", change_valid, 0);

    // Restock on the vend exit edge, then reset mid-change.
    coin(2'd3);
    tick(0, 0, 2'd0, 0, 1, 4'd3, 0);
    chk("s6_stock_net", stock, 3);
    chk("s6_amt6", change_amt, 6);
    do_reset();
    chk("s6_rst_cv", change_valid, 0);
    chk("s6_rst_credit", credit, 0);
    chk("s6_rst_stock", stock, INIT_STOCK);
    chk("s6_rst_busy", busy, 0);

    // Saturating restock, alone and on a vend edge.
    tick(0, 0, 2'd0, 0, 1, 4'd15, 0);
    chk("s7_sat", stock, 15);
    coin(2'd1);
    coin(2'd1);
    tick(0, 0, 2'd0, 0, 1, 4'd15, 0);
    chk("s7_sat_vend", stock, 15);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
